// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions for the arbiter slice:
//   - default address/data widths of the classic Wishbone bus
//   - arbiter state encoding (IDLE / BUSY)
//   - width helpers for byte selects, index fields and the watchdog counter
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Byte-select lanes for a data bus of dw bits.
  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width: holds values up to timeout without wrapping.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/arbiter_wb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority selector. Searches the request vector
// upward starting one past the last-served index, wrapping modulo NM, and
// returns the first requester found.
// Ports:
//   i_req  [NM-1:0]  request vector
//   i_last [GW-1:0]  index of the master served most recently
//   o_idx  [GW-1:0]  chosen index (0 when nothing requests)
//   o_vld            at least one request is present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NM = 2,
  parameter int GW = 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [GW-1:0] i_last,
  output logic [GW-1:0] o_idx,
  output logic          o_vld
);

  logic [GW-1:0] w_cand;
  logic [GW-1:0] w_idx;

  // Index that lies off positions above base, wrapped into 0..NM-1.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NM;
    return GW'(s);
  endfunction

  // Walk from the farthest candidate down to the nearest so the nearest
  // requester after i_last overwrites all others and ends up selected.
  always_comb begin
    w_cand = '0;
    w_idx  = '0;
    for (int i = NM; i >= 1; i--) begin
      w_cand = wrap_add(i_last, i);
      w_idx  = i_req[w_cand] ? w_cand : w_idx;
    end
  end

  assign o_idx = w_idx;
  assign o_vld = |i_req;

endmodule

// File: rtl/arbiter_wb.sv
// -----------------------------------------------------------------------------
// arbiter_wb
// N-to-1 classic Wishbone arbiter. Masters are granted round-robin; a grant
// lasts for the whole CYC of the granted master. The slave side is a
// combinational mux of the granted master, gated off while idle. A watchdog
// raises a one-cycle error pulse to the granted master when the slave leaves
// a strobe unacknowledged for TIMEOUT cycles (TIMEOUT=0 disables it).
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wbm_cyc/stb/we/sel/adr/dat_i  packed per-master request bundles (master k at slice k)
//   wbm_dat_o                  slave read data, broadcast to all masters
//   wbm_ack_o, wbm_err_o       per-master acknowledge / timeout error
//   wbs_cyc/stb/we/sel/adr/dat_o  slave request bundle
//   wbs_dat_i, wbs_ack_i       slave read data / acknowledge
// -----------------------------------------------------------------------------
module arbiter_wb
  import wb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NM-1:0]           wbm_cyc_i,
  input  logic [NM-1:0]           wbm_stb_i,
  input  logic [NM-1:0]           wbm_we_i,
  input  logic [NM*(DW/8)-1:0]    wbm_sel_i,
  input  logic [NM*AW-1:0]        wbm_adr_i,
  input  logic [NM*DW-1:0]        wbm_dat_i,
  output logic [DW-1:0]           wbm_dat_o,
  output logic [NM-1:0]           wbm_ack_o,
  output logic [NM-1:0]           wbm_err_o,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_we_o,
  output logic [DW/8-1:0]         wbs_sel_o,
  output logic [AW-1:0]           wbs_adr_o,
  output logic [DW-1:0]           wbs_dat_o,
  input  logic [DW-1:0]           wbs_dat_i,
  input  logic                    wbs_ack_i
);

  localparam int SW = sel_width(DW);
  localparam int GW = idx_width(NM);
  localparam int TW = cnt_width(TIMEOUT);

  localparam bit            WD_EN    = (TIMEOUT > 0);
  localparam int            TLAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TLAST    = TW'(TLAST_I);
  localparam logic [GW-1:0] LAST_RST = GW'(NM - 1);

  // Registers
  arb_state_e    r_state;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_last;
  logic [TW-1:0] r_tcnt;

  // Per-master views of the packed request buses
  logic [SW-1:0] w_sel_m [NM];
  logic [AW-1:0] w_adr_m [NM];
  logic [DW-1:0] w_dat_m [NM];

  // Signals of the currently granted master
  logic          w_cyc_g;
  logic          w_stb_g;
  logic          w_we_g;
  logic [SW-1:0] w_sel_g;
  logic [AW-1:0] w_adr_g;
  logic [DW-1:0] w_dat_g;

  logic [GW-1:0] w_pick;
  logic          w_pick_vld;
  logic          w_timeout;

  for (genvar k = 0; k < NM; k++) begin : g_unpack
    assign w_sel_m[k] = wbm_sel_i[k*SW +: SW];
    assign w_adr_m[k] = wbm_adr_i[k*AW +: AW];
    assign w_dat_m[k] = wbm_dat_i[k*DW +: DW];
  end

  rr_pick #(
    .NM (NM),
    .GW (GW)
  ) u_rr_pick (
    .i_req  (wbm_cyc_i),
    .i_last (r_last),
    .o_idx  (w_pick),
    .o_vld  (w_pick_vld)
  );

  // Select the granted master's request signals.
  always_comb begin
    w_cyc_g = wbm_cyc_i[r_gnt];
    w_stb_g = wbm_stb_i[r_gnt];
    w_we_g  = wbm_we_i[r_gnt];
    w_sel_g = w_sel_m[r_gnt];
    w_adr_g = w_adr_m[r_gnt];
    w_dat_g = w_dat_m[r_gnt];
  end

  // Drive the slave port from the granted master while busy; quiet when idle.
  // STB is qualified with CYC so a dropping master never presents a strobe.
  always_comb begin
    if (r_state == ST_BUSY) begin
      wbs_cyc_o = w_cyc_g;
      wbs_stb_o = w_cyc_g & w_stb_g;
      wbs_we_o  = w_we_g;
      wbs_sel_o = w_sel_g;
      wbs_adr_o = w_adr_g;
      wbs_dat_o = w_dat_g;
    end else begin
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_we_o  = 1'b0;
      wbs_sel_o = '0;
      wbs_adr_o = '0;
      wbs_dat_o = '0;
    end
  end

  // Watchdog fires on the last allowed stalled cycle; a same-cycle ack wins.
  assign w_timeout = WD_EN && wbs_stb_o && !wbs_ack_i && (r_tcnt == TLAST);

  // Route ack and error only to the granted master; wbs_stb_o is already 0
  // when idle, so stray acks are dropped.
  always_comb begin
    wbm_ack_o        = '0;
    wbm_err_o        = '0;
    wbm_ack_o[r_gnt] = wbs_ack_i & wbs_stb_o;
    wbm_err_o[r_gnt] = w_timeout;
  end

  assign wbm_dat_o = wbs_dat_i;

  // Arbitration FSM with grant, last-served pointer and watchdog counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= LAST_RST;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (w_pick_vld) begin
            r_gnt   <= w_pick;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!w_cyc_g) begin
            // Release; the next grant is decided from IDLE one cycle later.
            r_state <= ST_IDLE;
            r_last  <= r_gnt;
            r_tcnt  <= '0;
          end else if (!WD_EN || !wbs_stb_o || wbs_ack_i || w_timeout) begin
            r_tcnt <= '0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tcnt  <= '0;
        end
      endcase
    end
  end

endmodule
